// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VRAM slot arbiter.
//   owner_e    : who owns a VRAM slot (or who an in-flight access belongs to)
//   SLOT_OWNER : fixed 8-entry slot ownership table, indexed by slot number
// -----------------------------------------------------------------------------
package vram_pkg;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_PF,
        OWN_MO,
        OWN_AN,
        OWN_CPU
    } owner_e;

    // Slots 0/4 playfield, 1/5 motion objects, 2 alphanumerics, 3/6/7 CPU.
    localparam owner_e SLOT_OWNER [8] = '{
        OWN_PF, OWN_MO, OWN_AN, OWN_CPU,
        OWN_PF, OWN_MO, OWN_CPU, OWN_CPU
    };

endpackage

// File: rtl/vram_cpu_wait.sv
// -----------------------------------------------------------------------------
// vram_cpu_wait
// Counts slot ticks during which a CPU request sits unserved and raises a
// sticky timeout flag once the count reaches CPU_WAIT_MAX.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   slot_en      : slot-advance strobe (one tick per strobe)
//   pending      : CPU request raised and not yet acknowledged
//   served       : the pending request is being issued this cycle
//   cpu_timeout  : sticky overrun flag, cleared only by rst
// -----------------------------------------------------------------------------
module vram_cpu_wait
    import vram_pkg::*;
#(
    parameter int CPU_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic slot_en,
    input  logic pending,
    input  logic served,
    output logic cpu_timeout
);

    localparam int CNT_W = $clog2(CPU_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_WAIT_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (served) begin
            cnt_d = '0;
        end else if (slot_en && pending && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cpu_timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            // Raised on the same edge the count saturates; never cleared here.
            if (cnt_d == CNT_MAX) begin
                cpu_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Time-slot arbiter sharing one synchronous VRAM between the playfield (PF),
// motion-object (MO) and alphanumeric (AN) fetchers and a CPU port. An 8-slot
// wheel advances on slot_en; the owner of the current slot drives the VRAM
// address combinationally, and a one-stage owner tag routes the read data
// (one clock later) to the right consumer.
// Build option: define VRAM_VBLANK_CPU_EN to hand every slot to the CPU while
// VBLANK_b is low; otherwise VBLANK_b is ignored.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   slot_en                         : slot-advance strobe
//   VBLANK_b                        : active-low vertical blank
//   pf_addr, mo_addr, an_addr       : fetch addresses, bit 12 = bank
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU request (held until ack)
//   cpu_ack, cpu_rdata              : one-clock ack, read data (held)
//   cpu_timeout                     : sticky wait-overrun flag
//   vram_addr/bank/we/wdata         : VRAM command bus
//   vram_rdata                      : VRAM read data, one clock after address
//   pf/mo/an_data, pf/mo/an_valid   : fetch results and one-clock strobes
//   slot                            : current slot number
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int CPU_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slot_en,
    input  logic        VBLANK_b,
    input  logic [12:0] pf_addr,
    input  logic [12:0] mo_addr,
    input  logic [12:0] an_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_timeout,
    output logic [11:0] vram_addr,
    output logic        vram_bank,
    output logic        vram_we,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata,
    output logic [15:0] pf_data,
    output logic [15:0] mo_data,
    output logic [15:0] an_data,
    output logic        pf_valid,
    output logic        mo_valid,
    output logic        an_valid,
    output logic [2:0]  slot
);

    logic [2:0]  slot_q;
    owner_e      cur_owner;
    owner_e      issue_owner;
    owner_e      tag_q;
    logic        tag_rd_q;
    logic        cpu_pending;
    logic        cpu_serve;
    logic [15:0] pf_q;
    logic [15:0] mo_q;
    logic [15:0] an_q;
    logic [15:0] rdata_q;

    // Owner of the current slot.
    always_comb begin
        cur_owner = SLOT_OWNER[slot_q];
`ifdef VRAM_VBLANK_CPU_EN
        if (!VBLANK_b) begin
            cur_owner = OWN_CPU;
        end
`endif
    end

`ifndef VRAM_VBLANK_CPU_EN
    logic unused_vblank;
    assign unused_vblank = VBLANK_b;
`endif

    // A request still showing while its ack is out is the same request; it
    // must not be issued a second time.
    assign cpu_pending = cpu_req && !cpu_ack;
    assign cpu_serve   = slot_en && !rst && (cur_owner == OWN_CPU) && cpu_pending;

    // VRAM command bus, driven straight from the slot owner.
    always_comb begin
        vram_addr   = '0;
        vram_bank   = 1'b0;
        vram_we     = 1'b0;
        vram_wdata  = '0;
        issue_owner = OWN_NONE;
        if (slot_en) begin
            unique case (cur_owner)
                OWN_PF: begin
                    {vram_bank, vram_addr} = pf_addr;
                    issue_owner            = OWN_PF;
                end
                OWN_MO: begin
                    {vram_bank, vram_addr} = mo_addr;
                    issue_owner            = OWN_MO;
                end
                OWN_AN: begin
                    {vram_bank, vram_addr} = an_addr;
                    issue_owner            = OWN_AN;
                end
                OWN_CPU: begin
                    // No request: idle address 0, no write.
                    if (cpu_serve) begin
                        {vram_bank, vram_addr} = cpu_addr;
                        vram_we                = cpu_we;
                        vram_wdata             = cpu_wdata;
                        issue_owner            = OWN_CPU;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            tag_q    <= OWN_NONE;   // squashes anything issued this cycle
            tag_rd_q <= 1'b0;
            pf_q     <= '0;
            mo_q     <= '0;
            an_q     <= '0;
            rdata_q  <= '0;
        end else begin
            if (slot_en) begin
                slot_q <= slot_q + 3'd1;
            end
            tag_q    <= issue_owner;
            tag_rd_q <= !cpu_we;
            if (pf_valid) pf_q <= vram_rdata;
            if (mo_valid) mo_q <= vram_rdata;
            if (an_valid) an_q <= vram_rdata;
            if (cpu_ack && tag_rd_q) rdata_q <= vram_rdata;
        end
    end

    // Retire stage: the tag names the single consumer of this clock's read
    // data, so at most one strobe is ever high. Data passes through on the
    // strobe and is held in the capture register afterwards.
    assign pf_valid  = (tag_q == OWN_PF);
    assign mo_valid  = (tag_q == OWN_MO);
    assign an_valid  = (tag_q == OWN_AN);
    assign cpu_ack   = (tag_q == OWN_CPU);
    assign pf_data   = pf_valid ? vram_rdata : pf_q;
    assign mo_data   = mo_valid ? vram_rdata : mo_q;
    assign an_data   = an_valid ? vram_rdata : an_q;
    assign cpu_rdata = (cpu_ack && tag_rd_q) ? vram_rdata : rdata_q;
    assign slot      = slot_q;

    vram_cpu_wait #(
        .CPU_WAIT_MAX(CPU_WAIT_MAX)
    ) u_cpu_wait (
        .clk        (clk),
        .rst        (rst),
        .slot_en    (slot_en),
        .pending    (cpu_pending),
        .served     (cpu_serve),
        .cpu_timeout(cpu_timeout)
    );

endmodule
